// File: rtl/packet_framer.sv
`default_nettype none
// ============================================================================
// Module      : packet_framer
// Description : Frames FWFT payload FIFO data into packets for a host-bound
//               stream: two header words, then PAYLOAD_WORDS payload words.
//               Drives the header/payload mux select and the downstream
//               FIFO write enable. Optional trailer word carrying a 32-bit
//               payload sum is enabled by defining FRAMER_TRAILER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_framer #(
  parameter int unsigned PAYLOAD_WORDS = 256,
  parameter logic [15:0] MAGIC         = 16'hA55A
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        Fifo_Empty,
`ifdef FRAMER_TRAILER_EN
  input  logic [31:0] Fifo_Data,
`endif
  output logic        Fifo_Rd_En,
  input  logic        Out_Full,
  output logic        Out_Wr_En,
  output logic        Sel,
  output logic [31:0] Header_data,
  output logic        Busy,
  output logic        Pkt_Done,
  output logic [15:0] Seq_Num
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR0    = 3'd1;
  localparam logic [2:0] ST_HDR1    = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
`ifdef FRAMER_TRAILER_EN
  localparam logic [2:0] ST_TRAILER = 3'd4;
`endif

  localparam logic [15:0] LEN_WORD = 16'(PAYLOAD_WORDS);
  localparam logic [15:0] LAST_CNT = 16'(PAYLOAD_WORDS - 1);

  logic [2:0]  state;
  logic [15:0] word_cnt;

`ifdef FRAMER_TRAILER_EN
  logic [31:0] acc;
`endif

  // Handshake decode from registered state; a payload transfer needs both
  // room downstream and valid FIFO data, so pop and write are always equal.
  always_comb begin
    Out_Wr_En  = 1'b0;
    Fifo_Rd_En = 1'b0;
    Sel        = 1'b1;
    case (state)
      ST_HDR0, ST_HDR1: Out_Wr_En = ~Out_Full;
      ST_PAYLOAD: begin
        Sel        = 1'b0;
        Out_Wr_En  = ~Out_Full & ~Fifo_Empty;
        Fifo_Rd_En = ~Out_Full & ~Fifo_Empty;
      end
`ifdef FRAMER_TRAILER_EN
      ST_TRAILER: Out_Wr_En = ~Out_Full;
`endif
      default: ;
    endcase
  end

  assign Busy = (state != ST_IDLE);

  // Packet sequencer: header words, payload count, packet-end bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      word_cnt    <= 16'd0;
      Seq_Num     <= 16'd0;
      Header_data <= 32'd0;
      Pkt_Done    <= 1'b0;
    end else begin
      Pkt_Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Enable) begin
            state       <= ST_HDR0;
            Header_data <= {MAGIC, Seq_Num};
          end
        end
        ST_HDR0: begin
          if (Out_Wr_En) begin
            state       <= ST_HDR1;
            Header_data <= {16'h0000, LEN_WORD};
          end
        end
        ST_HDR1: begin
          if (Out_Wr_En) begin
            state    <= ST_PAYLOAD;
            word_cnt <= 16'd0;
          end
        end
        ST_PAYLOAD: begin
          if (Fifo_Rd_En) begin
            word_cnt <= word_cnt + 16'd1;
            if (word_cnt == LAST_CNT) begin
`ifdef FRAMER_TRAILER_EN
              // Trailer carries the sum including this final payload word.
              state       <= ST_TRAILER;
              Header_data <= acc + Fifo_Data;
`else
              state    <= ST_IDLE;
              Pkt_Done <= 1'b1;
              Seq_Num  <= Seq_Num + 16'd1;
`endif
            end
          end
        end
`ifdef FRAMER_TRAILER_EN
        ST_TRAILER: begin
          if (Out_Wr_En) begin
            state    <= ST_IDLE;
            Pkt_Done <= 1'b1;
            Seq_Num  <= Seq_Num + 16'd1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FRAMER_TRAILER_EN
  // Running modulo-2^32 sum of payload words, cleared as HDR0 is entered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc <= 32'd0;
    end else if (state == ST_IDLE && Enable) begin
      acc <= 32'd0;
    end else if (state == ST_PAYLOAD && Fifo_Rd_En) begin
      acc <= acc + Fifo_Data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_framer
// Description : Scoreboard bench for packet_framer. Models the FWFT payload
//               FIFO and the downstream FIFO; expected words are queued as
//               payload is loaded and retired as the framer writes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_framer;

  localparam int PW = 4;
`ifdef FRAMER_TRAILER_EN
  localparam int PKT_LEN = PW + 3;
`else
  localparam int PKT_LEN = PW + 2;
`endif

  logic        Clk = 1'b0;
  logic        Reset, Enable, Fifo_Empty, Out_Full;
  logic        Fifo_Rd_En, Out_Wr_En, Sel, Busy, Pkt_Done;
  logic [31:0] Header_data;
  logic [15:0] Seq_Num;
  logic [31:0] fifo_head;

  packet_framer #(.PAYLOAD_WORDS(PW), .MAGIC(16'hA55A)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Enable      (Enable),
    .Fifo_Empty  (Fifo_Empty),
`ifdef FRAMER_TRAILER_EN
    .Fifo_Data   (fifo_head),
`endif
    .Fifo_Rd_En  (Fifo_Rd_En),
    .Out_Full    (Out_Full),
    .Out_Wr_En   (Out_Wr_En),
    .Sel         (Sel),
    .Header_data (Header_data),
    .Busy        (Busy),
    .Pkt_Done    (Pkt_Done),
    .Seq_Num     (Seq_Num)
  );

  always #5 Clk = ~Clk;

  logic [31:0] fifo_q[$];
  logic [33:0] exp_q[$];   // {last_word, sel, data}
  logic [31:0] pl[PW];
  int n_cmp = 0, n_err = 0;
  int nwr, cyc, first_wr, last_wr;
  logic prev_last;
  bit force_full, force_empty;
  int full_after, full_len, full_left, empty_after, empty_len, empty_left;
  logic [15:0] seq_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic apply_inputs();
    fifo_head  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    Fifo_Empty = force_empty || (fifo_q.size() == 0);
    Out_Full   = force_full;
  endtask

  task automatic push_pkt(input logic [15:0] seq);
    logic [31:0] sum;
    sum = 32'h0;
    exp_q.push_back({1'b0, 1'b1, 16'hA55A, seq});
    exp_q.push_back({1'b0, 1'b1, 16'h0000, 16'(PW)});
    for (int i = 0; i < PW; i++) begin
      fifo_q.push_back(pl[i]);
`ifdef FRAMER_TRAILER_EN
      exp_q.push_back({1'b0, 1'b0, pl[i]});
`else
      exp_q.push_back({(i == PW - 1), 1'b0, pl[i]});
`endif
      sum = sum + pl[i];
    end
`ifdef FRAMER_TRAILER_EN
    exp_q.push_back({1'b1, 1'b1, sum});
`endif
    apply_inputs();
  endtask

  // One clock: check outputs at negedge, then update the FIFO model after the edge.
  task automatic step();
    logic [33:0] e;
    logic do_pop;
    @(negedge Clk);
    chk("pkt_done", {31'h0, Pkt_Done}, {31'h0, prev_last});
    chk("wr_while_full", {31'h0, Out_Wr_En & Out_Full}, 32'h0);
    chk("rd_while_empty", {31'h0, Fifo_Rd_En & Fifo_Empty}, 32'h0);
    prev_last = 1'b0;
    if (Out_Wr_En) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {31'h0, Out_Wr_En}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sel", {31'h0, Sel}, {31'h0, e[32]});
        chk("word", Sel ? Header_data : fifo_head, e[31:0]);
        chk("rd_en", {31'h0, Fifo_Rd_En}, {31'h0, ~e[32]});
        prev_last = e[33];
      end
      if (nwr == 0) first_wr = cyc;
      last_wr = cyc;
      nwr++;
    end else begin
      chk("rd_without_wr", {31'h0, Fifo_Rd_En}, 32'h0);
    end
    do_pop = Fifo_Rd_En;
    @(posedge Clk);
    #1;
    cyc++;
    if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (full_after >= 0 && nwr == full_after) begin
      full_left = full_len; full_after = -1;
    end
    force_full = (full_left > 0);
    if (full_left > 0) full_left--;
    if (empty_after >= 0 && nwr == empty_after) begin
      empty_left = empty_len; empty_after = -1;
    end
    force_empty = (empty_left > 0);
    if (empty_left > 0) empty_left--;
    apply_inputs();
  endtask

  task automatic start_test();
    nwr = 0; first_wr = 0; last_wr = 0;
    full_after = -1; empty_after = -1; full_left = 0; empty_left = 0;
  endtask

  // Raise Enable, drop it once en_off writes are seen, run until scoreboard drains.
  task automatic run(input int en_off, input int max_cyc);
    int n;
    n = 0;
    Enable = 1'b1;
    while (exp_q.size() > 0 && n < max_cyc) begin
      step();
      n++;
      if (nwr >= en_off) Enable = 1'b0;
    end
    chk("timeout_left", exp_q.size(), 32'h0);
    Enable = 1'b0;
    step();
    step();
  endtask

  initial begin
    cyc = 0; prev_last = 1'b0; seq_exp = 16'h0;
    force_full = 1'b0; force_empty = 1'b0;
    Reset = 1'b1; Enable = 1'b0;
    start_test();
    apply_inputs();
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_seq", {16'h0, Seq_Num}, 32'h0);
    chk("rst_hdr", Header_data, 32'h0);
    chk("rst_done", {31'h0, Pkt_Done}, 32'h0);
    chk("rst_sel", {31'h0, Sel}, 32'h1);
    chk("rst_wr", {31'h0, Out_Wr_En}, 32'h0);

    // Basic packet, no stalls.
    for (int i = 0; i < PW; i++) pl[i] = 32'(i + 1);
    start_test();
    push_pkt(seq_exp);
    run(1, 50);
    seq_exp++;
    chk("t1_writes", nwr, PKT_LEN);
    chk("t1_span", last_wr - first_wr, PKT_LEN - 1);
    chk("t1_seq", {16'h0, Seq_Num}, {16'h0, seq_exp});

    // Downstream full for 3 cycles in HDR1.
    start_test();
    full_after = 1; full_len = 3;
    push_pkt(seq_exp);
    run(1, 50);
    seq_exp++;
    chk("t2_writes", nwr, PKT_LEN);
    chk("t2_span", last_wr - first_wr, PKT_LEN - 1 + 3);
    chk("t2_seq", {16'h0, Seq_Num}, {16'h0, seq_exp});

    // Payload FIFO empty for 5 cycles after payload word 2.
    start_test();
    empty_after = 4; empty_len = 5;
    for (int i = 0; i < PW; i++) pl[i] = 32'h1000 + 32'(i);
    push_pkt(seq_exp);
    run(1, 50);
    seq_exp++;
    chk("t3_writes", nwr, PKT_LEN);
    chk("t3_span", last_wr - first_wr, PKT_LEN - 1 + 5);

    // Three back-to-back packets with Enable held.
    start_test();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < PW; i++) pl[i] = 32'($urandom);
      push_pkt(seq_exp + 16'(p));
    end
    run(2 * PKT_LEN + 1, 100);
    seq_exp = seq_exp + 16'd3;
    chk("t4_writes", nwr, 3 * PKT_LEN);
    chk("t4_span", last_wr - first_wr, 3 * PKT_LEN + 1);
    chk("t4_seq", {16'h0, Seq_Num}, {16'h0, seq_exp});

    // Reset while payload word 2 is being written.
    start_test();
    for (int i = 0; i < PW; i++) pl[i] = 32'h2000 + 32'(i);
    push_pkt(seq_exp);
    Enable = 1'b1;
    for (int n = 0; n < 20 && nwr < 3; n++) begin
      step();
      if (nwr >= 1) Enable = 1'b0;
    end
    chk("t5_reach", nwr, 3);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    apply_inputs();
    seq_exp = 16'h0;
    prev_last = 1'b0;
    chk("t5_busy", {31'h0, Busy}, 32'h0);
    chk("t5_seq", {16'h0, Seq_Num}, 32'h0);
    chk("t5_wr", {31'h0, Out_Wr_En}, 32'h0);
    repeat (4) step();
    chk("t5_no_more_wr", nwr, 4);
    start_test();
    for (int i = 0; i < PW; i++) pl[i] = 32'h3000 + 32'(i);
    push_pkt(seq_exp);
    run(1, 50);
    seq_exp++;
    chk("t5_writes", nwr, PKT_LEN);

`ifdef FRAMER_TRAILER_EN
    // Trailer sum wraps modulo 2^32.
    start_test();
    pl[0] = 32'hFFFF_FFFF; pl[1] = 32'h2; pl[2] = 32'h3; pl[3] = 32'h4;
    push_pkt(seq_exp);
    run(1, 50);
    seq_exp++;
    chk("t6_writes", nwr, 7);
    chk("t6_trailer", Header_data, 32'h0000_0008);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
